// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: boot address, datapath widths, FSM states
// and a small helper for halfword-aligning redirect targets.
package if_fetch_ctrl_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  // Boot address; if_pc resets to the same constant.
  localparam logic [ADDR_W-1:0] RAM_BEGIN = 16'h0000;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_t;

  // Instructions are halfword aligned, so bit 0 of any target is forced low.
  function automatic logic [ADDR_W-1:0] align_half(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(1);
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bundle of the fetch controller's buses: PC control towards if_pc, the IMEM
// req/ack port, the decode valid/ready port and the EX redirect input.
interface if_fetch_ctrl_if;
  import if_fetch_ctrl_pkg::*;

  logic               pc_rst;
  logic [ADDR_W-1:0]  pc_addr;
  logic               pc_en;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_addr;
  logic               redir_valid;
  logic [ADDR_W-1:0]  redir_addr;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               id_ready;
  logic               fetch_err;

  // Fetch controller side
  modport master (
    output pc_rst, pc_en, branch_taken, branch_addr,
    output imem_req, imem_addr,
    output instr_valid, instr, instr_pc, fetch_err,
    input  pc_addr, redir_valid, redir_addr, imem_ack, imem_rdata, id_ready
  );

  // Environment side: if_pc, IMEM, decode and EX
  modport slave (
    input  pc_rst, pc_en, branch_taken, branch_addr,
    input  imem_req, imem_addr,
    input  instr_valid, instr, instr_pc, fetch_err,
    output pc_addr, redir_valid, redir_addr, imem_ack, imem_rdata, id_ready
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: steers if_pc, runs the IMEM req/ack handshake,
// presents fetched words to decode and squashes wrong-path data on redirect.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_ctrl_if.master   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               fetch_err_q, fetch_err_d;
  logic [ADDR_W-1:0]  branch_addr_q, branch_addr_d;

  logic               pc_en;
  logic               branch_taken;
  logic               imem_req;
  logic               redirect;
  logic               timed_out;
  logic [ADDR_W-1:0]  redir_target;
  logic [CNT_W-1:0]   wait_cnt_inc;

  assign bus.pc_rst       = !rst;
  assign bus.pc_en        = pc_en;
  assign bus.branch_taken = branch_taken;
  assign bus.branch_addr  = branch_addr_d;
  assign bus.imem_req     = imem_req;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.fetch_err    = fetch_err_q;

  // Next-state logic plus the combinational PC-steering and IMEM request outputs.
  always_comb begin
    state_d       = state_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    wait_cnt_d    = wait_cnt_q;
    fetch_err_d   = fetch_err_q;
    branch_addr_d = branch_addr_q;
    pc_en         = 1'b0;
    branch_taken  = 1'b0;
    imem_req      = 1'b0;

    redir_target  = align_half(bus.redir_addr);
    redirect      = bus.redir_valid &&
                    (state_q inside {ST_FETCH, ST_HOLD, ST_DRAIN});
    timed_out     = !bus.imem_ack && (wait_cnt_q >= CNT_LAST);
    wait_cnt_inc  = (wait_cnt_q >= CNT_LAST) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

    if (redirect) begin
      pc_en         = 1'b1;
      branch_taken  = 1'b1;
      branch_addr_d = redir_target;
      instr_valid_d = 1'b0;
    end

    case (state_q)
      ST_BOOT: begin
        state_d     = ST_FETCH;
        imem_addr_d = bus.pc_addr;
        wait_cnt_d  = '0;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          wait_cnt_d = '0;
          if (bus.imem_ack) begin
            state_d     = ST_FETCH;
            imem_addr_d = redir_target;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (bus.imem_ack) begin
          instr_d       = bus.imem_rdata;
          instr_pc_d    = imem_addr_q;
          instr_valid_d = 1'b1;
          state_d       = ST_HOLD;
        end else if (timed_out) begin
          fetch_err_d = 1'b1;
          state_d     = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          imem_addr_d = redir_target;
          wait_cnt_d  = '0;
          state_d     = ST_FETCH;
        end else if (bus.id_ready) begin
          pc_en         = 1'b1;
          instr_valid_d = 1'b0;
          imem_addr_d   = bus.pc_addr + ADDR_W'(2);
          wait_cnt_d    = '0;
          state_d       = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        imem_req = 1'b1;
        if (redirect) begin
          wait_cnt_d = bus.imem_ack ? '0 : wait_cnt_inc;
        end else if (bus.imem_ack) begin
          imem_addr_d = bus.pc_addr;
          wait_cnt_d  = '0;
          state_d     = ST_FETCH;
        end else if (timed_out) begin
          fetch_err_d = 1'b1;
          state_d     = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end

      ST_ERR: begin
        instr_valid_d = 1'b0;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      imem_addr_q   <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      wait_cnt_q    <= '0;
      fetch_err_q   <= 1'b0;
      branch_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_err_q   <= fetch_err_d;
      branch_addr_q <= branch_addr_d;
    end
  end

endmodule
